// File: rtl/regfile_pkg.sv
// Shared constants and flattened-bus slice helpers for the bypassing register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_ADDR = 0;

    // LSB of port k within a flattened bus of per-port width w.
    function automatic int port_slice(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection; issue sets, writeback clears, set wins.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NREAD    = 2,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREAD*AW-1:0] rd_addr,
    output logic [NREAD-1:0]    rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic             set_ok;
    logic             clr_ok;

    assign set_ok   = iss_en && !(ZERO_REG && iss_addr == AW'(ZERO_ADDR));
    assign clr_ok   = wr_en  && !(ZERO_REG && wr_addr  == AW'(ZERO_ADDR));
    assign set_mask = {{(NREGS-1){1'b0}}, set_ok} << iss_addr;
    assign clr_mask = {{(NREGS-1){1'b0}}, clr_ok} << wr_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign busy_vec = busy;

    for (genvar k = 0; k < NREAD; k++) begin : g_busy
        logic [AW-1:0] ra;
        assign ra = rd_addr[port_slice(k, AW) +: AW];
        // A same-cycle writeback to the source is forwarded, so it is no longer a hazard.
        assign rd_busy[k] = !reset && busy[ra]
                            && !(wr_en && wr_addr == ra)
                            && !(ZERO_REG && ra == AW'(ZERO_ADDR));
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Integer register file: NREAD combinational read ports, one write port with write-through bypass.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NREAD    = 2,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;

    assign wr_ok = wr_en && !(ZERO_REG && wr_addr == AW'(ZERO_ADDR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[port_slice(k, AW) +: AW];
        // Bypass must not leak wr_data while reset holds the outputs at zero.
        assign rd_data[port_slice(k, XLEN) +: XLEN] =
            (reset || (ZERO_REG && ra == AW'(ZERO_ADDR))) ? '0 :
            (wr_en && wr_addr == ra)                      ? wr_data :
                                                            regs[ra];
    end

    regfile_scoreboard #(
        .NREGS   (NREGS),
        .NREAD   (NREAD),
        .AW      (AW),
        .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .busy_vec(busy_vec)
    );

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor to the core's integer register file.
- Provides NREAD combinational read ports and one posedge write port with write-through bypass.
- Register 0 is hardwired to zero.
- Per-register busy scoreboard lets the decode/issue stage detect RAW hazards against in-flight producers.
- Sits between decode (read/issue) and writeback in the pipelined datapath.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers (power of two, at least 2).
- NREAD, 2, number of independent read ports (1..4).
- AW, $clog2(NREGS), address width (derived; not overridden).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 behaves like any other.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NREAD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rd_busy  out  NREAD  port k source is pending (RAW hazard).
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback value.
- iss_en  in  1  issue: mark iss_addr busy.
- iss_addr  in  AW  destination of the instruction being issued.
- busy_vec  out  NREGS  raw scoreboard state, for debug and perf counters.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - All NREGS registers are cleared to 0.
  - All busy bits are cleared.
  - While reset is high, every rd_data = 0 and every rd_busy = 0, regardless of address.
- Write:
  - At posedge clk with wr_en=1, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - With ZERO_REG=1 and wr_addr=0, the write and the busy clear are both dropped.
- Read: combinational, zero latency. rd_data[k] is selected in this priority order:
  - ZERO_REG && rd_addr[k]==0 -> 0.
  - Else wr_en && wr_addr==rd_addr[k] -> wr_data (same-cycle bypass).
  - Else regs[rd_addr[k]].
- Scoreboard:
  - At posedge with iss_en=1, busy[iss_addr] <= 1.
  - With ZERO_REG=1, issue to register 0 is ignored; busy[0] stays 0.
  - If iss_en and wr_en target the same address in the same cycle, set wins: busy ends 1 (a newer producer was issued) and the data write still occurs.
  - rd_busy[k] = busy[rd_addr[k]] && !(wr_en && wr_addr==rd_addr[k]), so a same-cycle writeback resolves the hazard via the bypass.
  - rd_busy[k] is 0 when ZERO_REG && rd_addr[k]==0.
- Multiple read ports may address the same register; each sees identical data and busy values.
- No write-write conflict is possible (single write port).
- Reset asserted mid-operation:
  - Outputs go to 0 immediately (asynchronous).
  - A concurrent wr_en or iss_en in that cycle has no effect.
- X-safety: with wr_en=0, wr_addr and wr_data are don't-care. With iss_en=0, iss_addr is don't-care.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN/NREGS constants;
  - function port_slice helpers for the flattened read buses;
  - localparam ZERO_ADDR.
- One natural sub-module: regfile_scoreboard.
  - Owns the NREGS busy bits, set/clear priority and the rd_busy qualification.
  - Instantiated once. The data array, bypass mux and zero-register logic stay in the top.

Test Plan:
- Reset then read: assert reset, release; read x0..x31 on both ports -> all rd_data=0, busy_vec=0.
- Write/readback: wr x5=0xDEAD_BEEF_0000_0001 at edge N; rd_addr0=5 at cycle N+1 -> 0xDEADBEEF00000001, rd_busy0=0.
- Bypass: in the same cycle as wr_en x7=0x1234, drive rd_addr1=7 -> rd_data1=0x1234 combinationally, before the edge.
- Zero register: wr x0=0xFFFF, iss_en x0 -> rd x0=0, busy_vec[0]=0.
- Scoreboard: iss x9 at edge N -> rd_busy for x9=1 from N+1. Writeback x9=42 at edge N+3 -> during that cycle rd_busy=0 with data 42; after the edge busy_vec[9]=0. Simultaneous iss x9 and wr x9=55 -> data 55, busy_vec[9]=1.
- Async reset mid-run: registers loaded and x3 busy; pulse reset between edges -> rd_data and rd_busy drop to 0 immediately; after release x3 reads 0 and is not busy.
